ysyx_22050039_seq_ctrl: RTL

Multi-cycle sequencer for the IFU/IDU/EXU datapath. Issues instruction-memory requests, latches the returned instruction, and steps decode, execute and writeback one instruction at a time. Waits on multi-cycle EXU ops, advances the PC only after writeback, and halts on ebreak or fetch timeout. Sits inside the CPU top between the instruction memory port and the datapath units.

---
 rtl/ysyx_22050039_seq_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ysyx_22050039_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the IFU/IDU/EXU datapath.
// Optional performance counters are enabled by defining YSYX_22050039_PERF_CNT_EN.
module ysyx_22050039_seq_ctrl #(
    parameter int XLEN          = 64,
    parameter int INST_LEN      = 32,
    parameter int FETCH_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    input  logic                imem_resp_valid,
    input  logic [INST_LEN-1:0] imem_rdata,
    output logic [INST_LEN-1:0] inst,
    output logic                idu_en,
    output logic                exu_start,
    input  logic                exu_done,
    input  logic                is_ebreak,
    output logic                wb_en,
    output logic                pc_en,
    output logic                halt,
    output logic                halt_err,
`ifdef YSYX_22050039_PERF_CNT_EN
    output logic [XLEN-1:0]     perf_cycle,
    output logic [XLEN-1:0]     perf_instret,
`endif
    output logic [2:0]          state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(FETCH_TIMEOUT - 1);

    logic [2:0]       next_state;
    logic [CNT_W-1:0] fetch_cnt;
    logic             exec_first;
    logic             fetch_hit;

    // An instruction arrives either alongside the request handshake or later in FETCH.
    assign fetch_hit = ((state == S_REQ) && imem_req_ready && imem_resp_valid) ||
                       ((state == S_FETCH) && imem_resp_valid);

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   next_state = S_REQ;
            S_REQ: begin
                if (imem_req_ready) begin
                    next_state = imem_resp_valid ? S_DECODE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_resp_valid) begin
                    next_state = S_DECODE;
                end else if (fetch_cnt == FETCH_LAST) begin
                    next_state = S_HALT;
                end
            end
            S_DECODE: next_state = is_ebreak ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (exu_done) begin
                    next_state = S_WB;
                end
            end
            S_WB:     next_state = S_REQ;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            fetch_cnt  <= '0;
            exec_first <= 1'b0;
            inst       <= '0;
            halt       <= 1'b0;
            halt_err   <= 1'b0;
        end else begin
            state      <= next_state;
            exec_first <= (state != S_EXEC) && (next_state == S_EXEC);
            if (state == S_REQ) begin
                fetch_cnt <= '0;
            end else if ((state == S_FETCH) && !imem_resp_valid) begin
                fetch_cnt <= fetch_cnt + 1'b1;
            end
            if (fetch_hit) begin
                inst <= imem_rdata;
            end
            // HALT is absorbing, so the cause is written exactly once on entry.
            if ((state != S_HALT) && (next_state == S_HALT)) begin
                halt     <= 1'b1;
                halt_err <= (state == S_FETCH);
            end
        end
    end

    assign imem_req_valid = (state == S_REQ);
    assign idu_en         = (state == S_DECODE);
    assign exu_start      = (state == S_EXEC) && exec_first;
    assign wb_en          = (state == S_WB);
    assign pc_en          = (state == S_WB);

`ifdef YSYX_22050039_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycle   <= '0;
            perf_instret <= '0;
        end else begin
            if ((state != S_IDLE) && (state != S_HALT)) begin
                perf_cycle <= perf_cycle + 1'b1;
            end
            if (wb_en) begin
                perf_instret <= perf_instret + 1'b1;
            end
        end
    end
`endif

endmodule
